// File: rtl/timer_bank_mmio.sv
// timer_bank_mmio: a bank of NCH independent memory-mapped up-counting timers.
// Each channel has a reload value (TH), a live counter (TL), a control word
// (TCON) and a prescaler (PRESC). Channel k occupies four words at BASE + 16*k.
// A shared STATUS word sits just past the last channel and exposes all pending
// flags, which software clears by writing 1s (write-1-to-clear).
module timer_bank_mmio #(
  parameter logic [31:0] BASE = 32'h4000_0100,
  parameter int          NCH  = 4,
  parameter int          W    = 32,
  parameter int          PW   = 16
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic            PC_31,
  output logic            irqout,
  output logic [NCH-1:0]  irq_vec
);

  localparam logic [31:0] BANK_BYTES = 32'(16 * NCH);

  localparam logic [1:0] REG_TH    = 2'd0;
  localparam logic [1:0] REG_TL    = 2'd1;
  localparam logic [1:0] REG_TCON  = 2'd2;
  localparam logic [1:0] REG_PRESC = 2'd3;

  // Address decode. Subtracting BASE lets one comparison bound the whole bank;
  // the channel index is offset[6:4], which covers up to eight channels.
  logic [31:0] offset;
  logic        aligned;
  logic        ch_hit;
  logic        status_hit;
  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;

  assign offset     = addr - BASE;
  assign aligned    = (addr[1:0] == 2'b00);
  assign ch_hit     = aligned && (offset < BANK_BYTES);
  assign status_hit = aligned && (offset == BANK_BYTES);
  assign ch_sel     = offset[6:4];
  assign reg_sel    = offset[3:2];

  // Per-channel architectural state.
  logic [W-1:0]   th    [NCH];
  logic [W-1:0]   tl    [NCH];
  logic [PW-1:0]  presc [NCH];
  logic [PW-1:0]  pc    [NCH];
  logic [NCH-1:0] en;
  logic [NCH-1:0] ie;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] oneshot;

  logic [NCH-1:0] sel;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] ovf;

  // Channel select plus the tick/overflow qualifiers derived from current state.
  always_comb begin
    sel  = '0;
    tick = '0;
    ovf  = '0;
    for (int k = 0; k < NCH; k++) begin
      sel[k]  = ch_hit && (ch_sel == 3'(k));
      tick[k] = en[k] && (pc[k] == presc[k]);
      ovf[k]  = tick[k] && (tl[k] == {W{1'b1}});
    end
  end

  // Register updates. Bus writes to TL win over counting, a PRESC write
  // restarts the prescaler, and hardware setting PEND or clearing EN on a
  // one-shot overflow wins over a same-cycle software write.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        th[k]    <= '0;
        tl[k]    <= '0;
        presc[k] <= '0;
        pc[k]    <= '0;
      end
      en      <= '0;
      ie      <= '0;
      pend    <= '0;
      oneshot <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wr && sel[k] && (reg_sel == REG_TH))
          th[k] <= wdata[W-1:0];

        if (wr && sel[k] && (reg_sel == REG_TL))
          tl[k] <= wdata[W-1:0];
        else if (tick[k])
          tl[k] <= ovf[k] ? th[k] : tl[k] + W'(1);

        if (wr && sel[k] && (reg_sel == REG_PRESC)) begin
          presc[k] <= wdata[PW-1:0];
          pc[k]    <= '0;
        end else if (!en[k] || tick[k]) begin
          pc[k] <= '0;
        end else begin
          pc[k] <= pc[k] + PW'(1);
        end

        if (wr && sel[k] && (reg_sel == REG_TCON)) begin
          ie[k]      <= wdata[1];
          oneshot[k] <= wdata[3];
        end

        if (ovf[k] && oneshot[k])
          en[k] <= 1'b0;
        else if (wr && sel[k] && (reg_sel == REG_TCON))
          en[k] <= wdata[0];

        if (ovf[k] && ie[k])
          pend[k] <= 1'b1;
        else if ((wr && sel[k] && (reg_sel == REG_TCON) && !wdata[2]) ||
                 (wr && status_hit && wdata[k]))
          pend[k] <= 1'b0;
      end
    end
  end

  // Read mux: zero-extended register value on a valid hit, otherwise zero.
  always_comb begin
    rdata = '0;
    if (rd && status_hit) begin
      rdata = 32'(pend);
    end else if (rd && ch_hit) begin
      for (int k = 0; k < NCH; k++) begin
        if (sel[k]) begin
          case (reg_sel)
            REG_TH:   rdata = 32'(th[k]);
            REG_TL:   rdata = 32'(tl[k]);
            REG_TCON: rdata = 32'({oneshot[k], pend[k], ie[k], en[k]});
            default:  rdata = 32'(presc[k]);
          endcase
        end
      end
    end
  end

  assign irq_vec = pend & ie;
  assign irqout  = ~PC_31 & (|irq_vec);

endmodule
